// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: splits RV32I accesses into byte/word beats for data_mem.
// Latency 1 (error), N+1 (store) or N+2 (load) cycles; req_ready only in IDLE, one request in flight.
module load_store_unit #(
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_size,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]  r_state;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_beat;
    logic [1:0]  r_last;
    logic        r_word;
    logic        r_err;
    logic [31:0] r_asm;
    logic [31:0] r_rdata;

    logic        w_inval;
    logic        w_mis;
    logic        w_err;
    logic        w_word;
    logic [1:0]  w_last;
    logic        w_access;
    logic [31:0] w_asm;
    logic [31:0] w_ext;

    always_comb begin
        w_inval = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) || (req_we && req_funct3[2]);
        w_mis   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                  ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        w_err   = w_inval || ((ALLOW_MISALIGNED == 0) && w_mis);
        w_word  = (req_funct3[1:0] == 2'b10) && (req_addr[1:0] == 2'b00);
        case (req_funct3[1:0])
            2'b01:   w_last = 2'd1;
            2'b10:   w_last = w_word ? 2'd0 : 2'd3;
            default: w_last = 2'd0;
        endcase
    end

    // The last read beat's data arrives while in WAIT, so merge it here rather than registering first.
    always_comb begin
        w_asm = r_asm;
        if (r_word)
            w_asm = mem_rdata;
        else
            w_asm[{r_last, 3'b000} +: 8] = mem_rdata[7:0];
        case (r_f3)
            3'b000:  w_ext = {{24{w_asm[7]}}, w_asm[7:0]};
            3'b001:  w_ext = {{16{w_asm[15]}}, w_asm[15:0]};
            3'b100:  w_ext = {24'b0, w_asm[7:0]};
            3'b101:  w_ext = {16'b0, w_asm[15:0]};
            default: w_ext = w_asm;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_f3    <= 3'b0;
            r_addr  <= 32'b0;
            r_wdata <= 32'b0;
            r_beat  <= 2'd0;
            r_last  <= 2'd0;
            r_word  <= 1'b0;
            r_err   <= 1'b0;
            r_asm   <= 32'b0;
            r_rdata <= 32'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_f3    <= req_funct3;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_beat  <= 2'd0;
                        r_last  <= w_last;
                        r_word  <= w_word;
                        r_asm   <= 32'b0;
                        r_err   <= w_err;
                        if (w_err) begin
                            r_rdata <= 32'b0;
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!r_we && (r_beat != 2'd0))
                        r_asm[{r_beat - 2'd1, 3'b000} +: 8] <= mem_rdata[7:0];
                    if (r_beat == r_last) begin
                        if (r_we) begin
                            r_rdata <= 32'b0;
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else begin
                        r_beat <= r_beat + 2'd1;
                    end
                end
                S_WAIT: begin
                    r_rdata <= w_ext;
                    r_state <= S_RESP;
                end
                default: begin
                    r_beat  <= 2'd0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_access   = (r_state == S_ACCESS);
    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_err   = (r_state == S_RESP) && r_err;
    assign resp_rdata = r_rdata;
    assign mem_read   = w_access && !r_we;
    assign mem_write  = w_access && r_we;
    assign mem_size   = w_access && r_word;
    assign mem_addr   = !w_access ? 32'b0 : (r_word ? r_addr : r_addr + {30'b0, r_beat});
    assign mem_wdata  = !w_access ? 32'b0 :
                        (r_word ? r_wdata : {24'b0, r_wdata[{r_beat, 3'b000} +: 8]});

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit that sits directly upstream of `data_mem`. It accepts one RV32I load/store request from the execute stage and drives `data_mem`, which supports only byte and word transfers. Halfword and misaligned accesses are split into sequential byte beats. Load data is little-endian assembled and sign- or zero-extended before a single-cycle response to writeback.

## Interface
- `ALLOW_MISALIGNED`, default 1: 1 = split misaligned accesses into byte beats; 0 = reject them with `resp_err`.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle and able to accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width code. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_err` out 1: request rejected; qualified by `resp_valid`.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `mem_size` out 1: to `data_mem`. 0 = byte (`[7:0]`), 1 = word.
- `mem_read` out 1, `mem_write` out 1: `data_mem` strobes.
- `mem_addr` out 32, `mem_wdata` out 32: `data_mem` address and write data.
- `mem_rdata` in 32: `data_mem` read data, valid the cycle after `mem_read`.

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP. `req_ready` = (state == IDLE).
- Handshake: a request is accepted on the edge where `req_valid && req_ready`. All request fields are registered; inputs are ignored after acceptance.
- Beat count N:
  - B/BU: 1 byte beat.
  - Word with addr[1:0] = 0: 1 word beat.
  - H/HU: 2 byte beats at any alignment.
  - Word with addr[1:0] ≠ 0: 4 byte beats.
- Invalid funct3:
  - 011, 110, 111 are invalid.
  - Store with funct3 = 100 or 101 is invalid.
- Error path: invalid funct3, or any misaligned H/W access when `ALLOW_MISALIGNED` = 0. The FSM goes IDLE → RESP with `resp_err` = 1 and issues no memory strobe.
- Beat k (0..N-1) in ACCESS:
  - Byte beat: `mem_addr` = `req_addr` + k (modulo 2^32 wrap), `mem_size` = 0, `mem_wdata` = {24'b0, `req_wdata`[8k+7:8k]}.
  - Word beat: `mem_addr` = `req_addr`, `mem_size` = 1, `mem_wdata` = `req_wdata`.
  - Exactly one of `mem_read` / `mem_write` is high in each ACCESS cycle.
- Loads:
  - Byte k of the result is captured from `mem_rdata`[7:0] one cycle after beat k. A word beat captures `mem_rdata`[31:0].
  - The final capture occurs in WAIT.
  - The assembled value is sign-extended for B and H, zero-extended for BU and HU.
- Stores skip WAIT.
- `resp_rdata` is held until the next `resp_valid`.
- `mem_read`, `mem_write`, `mem_size`, `mem_addr`, `mem_wdata` are 0 outside ACCESS.

## Timing
- Reset values: state IDLE, `req_ready` 1, all other outputs 0, beat counter 0.
- Cycle numbering: acceptance edge = end of cycle 0. Beats occupy cycles 1..N.
- Stores: RESP in cycle N+1.
- Loads: WAIT in cycle N+1, RESP in cycle N+2.
- Errors: RESP in cycle 1.
- RESP lasts exactly one cycle (`req_ready` = 0). IDLE follows, so back-to-back requests are spaced by at least one idle cycle.
- Latency from acceptance to `resp_valid`:
  - SB/SW aligned: 2.
  - SH: 3.
  - LB/LW aligned: 3.
  - LH: 4.
  - SW misaligned: 5.
  - LW misaligned: 6.
- Address wrap: byte beats at 0xFFFFFFFF wrap to 0x00000000; this is not an error.
- Reset mid-operation: the access is aborted immediately and no further strobes are issued. Bytes already written remain in `data_mem`. No `resp_valid` is produced.
- `req_valid` asserted while `req_ready` = 0 is ignored. The upstream stage holds the request until it is accepted.

## Test plan
- SB, addr 1, wdata 0x000000FF; then LBU addr 1 → one byte beat each. LBU `resp_rdata` = 0x000000FF at cycle 3. LB repeat → 0xFFFFFFFF.
- SW aligned, addr 4, wdata 0x00000400; then LW addr 4 → single word beat (`mem_size` = 1). `resp_rdata` = 0x00000400. Latencies 2 and 3.
- SH, addr 3, wdata 0x8001; then LH addr 3 → byte beats at 3 and 4 writing 0x01 then 0x80. LH returns 0xFFFF8001; LHU returns 0x00008001.
- SW misaligned, addr 0xFFFFFFFE, wdata 0xA1B2C3D4 → beats at addresses FE, FF, 0, 1 with bytes D4, C3, B2, A1. LW at same address returns 0xA1B2C3D4 at cycle 6.
- With `ALLOW_MISALIGNED` = 0, LW addr 2 → `resp_valid` and `resp_err` at cycle 1, no `mem_read`. funct3 = 011 gives the same result.
- Assert `rst_n` low during beat 2 of a misaligned SW → strobes drop immediately, no `resp_valid`, `req_ready` = 1 after release.
